// File: rtl/axi4_rd_responder.sv
// AXI4 read-channel responder: queues AR requests and walks each burst through a
// synchronous word-memory port, returning one R beat per transfer in acceptance order.
module axi4_rd_responder #(
  parameter int unsigned ID_W     = 2,
  parameter int unsigned AQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ID_W-1:0] arid,
  input  logic [31:0]     araddr,
  input  logic [7:0]      arlen,
  input  logic [2:0]      arsize,
  input  logic [1:0]      arburst,
  input  logic            arlock,
  input  logic [3:0]      arcache,
  input  logic [2:0]      arprot,
  input  logic [3:0]      arqos,
  input  logic [3:0]      arregion,
  input  logic            arvalid,
  output logic            arready,
  output logic [ID_W-1:0] rid,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic            rvalid,
  input  logic            rready,
  output logic            mem_req,
  output logic [31:0]     mem_addr,
  input  logic [31:0]     mem_rdata
);

  localparam int unsigned AW = (AQ_DEPTH > 1) ? $clog2(AQ_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     addr;
    logic [7:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
  } ar_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_CAP, S_RESP} state_t;

  ar_t             r_q_mem [AQ_DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count, w_count_nxt;
  logic            r_arready, w_arready_nxt;

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_cur_addr, w_cur_addr_nxt;
  logic [7:0]      r_beats_left, w_beats_nxt;
  logic [7:0]      r_len, w_len_nxt;
  logic [2:0]      r_size, w_size_nxt;
  logic [1:0]      r_burst, w_burst_nxt;
  logic            r_err, w_err_nxt;

  logic [ID_W-1:0] r_rid, w_rid_nxt;
  logic [31:0]     r_rdata, w_rdata_nxt;
  logic            r_rvalid, w_rvalid_nxt;
  logic            r_rlast, w_rlast_nxt;
  logic [1:0]      r_rresp, w_rresp_nxt;
  logic            r_mem_req, w_mem_req_nxt;
  logic [31:0]     r_mem_addr, w_mem_addr_nxt;

  logic            w_push, w_pop;
  ar_t             w_head, w_ar_in;
  logic            w_head_err;
  logic [31:0]     w_step, w_wrap_len, w_adv_addr;
  logic            w_unused;

  // Sideband AR attributes carry no meaning for this responder
  assign w_unused = ^{arlock, arcache, arprot, arqos, arregion};

  assign w_push  = arvalid && r_arready;
  assign w_head  = r_q_mem[r_rd_ptr];
  assign w_ar_in = '{id: arid, addr: araddr, len: arlen, size: arsize, burst: arburst};

  assign w_head_err = (w_head.size > 3'd2) || (w_head.burst == 2'd3) ||
                      ((w_head.burst == 2'd2) &&
                       !((w_head.len == 8'd1) || (w_head.len == 8'd3) ||
                         (w_head.len == 8'd7) || (w_head.len == 8'd15)));

  assign w_step     = 32'd1 << r_size;
  assign w_wrap_len = (32'(r_len) + 32'd1) << r_size;

  // Next beat address; arithmetic wraps silently at 2^32
  always_comb begin
    w_adv_addr = r_cur_addr;
    case (r_burst)
      2'd1:    w_adv_addr = (r_cur_addr & ~(w_step - 32'd1)) + w_step;
      2'd2:    w_adv_addr = (r_cur_addr & ~(w_wrap_len - 32'd1)) |
                            ((r_cur_addr + w_step) & (w_wrap_len - 32'd1));
      default: w_adv_addr = r_cur_addr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pop          = 1'b0;
    w_cur_addr_nxt = r_cur_addr;
    w_beats_nxt    = r_beats_left;
    w_len_nxt      = r_len;
    w_size_nxt     = r_size;
    w_burst_nxt    = r_burst;
    w_err_nxt      = r_err;
    w_rid_nxt      = r_rid;
    w_rdata_nxt    = r_rdata;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop          = 1'b1;
          w_cur_addr_nxt = w_head.addr;
          w_beats_nxt    = w_head.len;
          w_len_nxt      = w_head.len;
          w_size_nxt     = w_head.size;
          w_burst_nxt    = w_head.burst;
          w_err_nxt      = w_head_err;
          w_rid_nxt      = w_head.id;
          if (w_head_err) begin
            w_rdata_nxt = '0;
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: w_state_nxt = S_CAP;
      S_CAP: begin
        w_rdata_nxt = mem_rdata;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rready) begin
          if (r_beats_left == 8'd0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_beats_nxt    = r_beats_left - 8'd1;
            w_cur_addr_nxt = w_adv_addr;
            w_state_nxt    = r_err ? S_RESP : S_REQ;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Outputs are registered from the upcoming state so they align with it
    w_rvalid_nxt   = (w_state_nxt == S_RESP);
    w_rlast_nxt    = w_rvalid_nxt && (w_beats_nxt == 8'd0);
    w_rresp_nxt    = (w_rvalid_nxt && w_err_nxt) ? 2'b10 : 2'b00;
    w_mem_req_nxt  = (w_state_nxt == S_REQ);
    w_mem_addr_nxt = w_mem_req_nxt ? {w_cur_addr_nxt[31:2], 2'b00} : r_mem_addr;
    w_count_nxt    = r_count + CW'(w_push) - CW'(w_pop);
    w_arready_nxt  = (w_count_nxt != CW'(AQ_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (w_push) r_q_mem[r_wr_ptr] <= w_ar_in;
  end

  // arready stays low through reset and rises on the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_arready    <= 1'b0;
      r_cur_addr   <= '0;
      r_beats_left <= '0;
      r_len        <= '0;
      r_size       <= '0;
      r_burst      <= '0;
      r_err        <= 1'b0;
      r_rid        <= '0;
      r_rdata      <= '0;
      r_rvalid     <= 1'b0;
      r_rlast      <= 1'b0;
      r_rresp      <= '0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count      <= w_count_nxt;
      r_arready    <= w_arready_nxt;
      r_cur_addr   <= w_cur_addr_nxt;
      r_beats_left <= w_beats_nxt;
      r_len        <= w_len_nxt;
      r_size       <= w_size_nxt;
      r_burst      <= w_burst_nxt;
      r_err        <= w_err_nxt;
      r_rid        <= w_rid_nxt;
      r_rdata      <= w_rdata_nxt;
      r_rvalid     <= w_rvalid_nxt;
      r_rlast      <= w_rlast_nxt;
      r_rresp      <= w_rresp_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
    end
  end

  assign arready  = r_arready;
  assign rid      = r_rid;
  assign rdata    = r_rdata;
  assign rresp    = r_rresp;
  assign rlast    = r_rlast;
  assign rvalid   = r_rvalid;
  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;

endmodule

// File: tb/tb_axi4_rd_responder.sv
// Scoreboard bench for axi4_rd_responder: expected beats and memory addresses are
// queued at AR acceptance and compared as the DUT produces them.
module tb_axi4_rd_responder;
  localparam int unsigned ID_W     = 2;
  localparam int unsigned AQ_DEPTH = 2;

  logic            clk, rst_n;
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid, arready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast, rvalid, rready;
  logic            mem_req;
  logic [31:0]     mem_addr, mem_rdata;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    int          gap;
    int          first_at;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] mem_q[$];
  beat_t       mon_e;
  int n_checks = 0, n_fail = 0;
  int cyc = 0, n_hs = 0, start_cyc = 0, last_hs_cyc = 0;
  bit in_beat = 0;
  int t0, t1, t2, t3, n0;

  axi4_rd_responder #(.ID_W(ID_W), .AQ_DEPTH(AQ_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(1'b0), .arcache(4'h0), .arprot(3'h0), .arqos(4'h0), .arregion(4'h0),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  // Synchronous memory: data appears the cycle after the strobe and is held
  always @(posedge clk) if (mem_req) mem_rdata <= mem_word(mem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_model(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit gap_en,
                            input int first_at);
    bit err;
    logic [31:0] a, step, l;
    err  = (size > 3'd2) || (burst == 2'd3) ||
           ((burst == 2'd2) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    a    = addr;
    step = 32'd1 << size;
    l    = (32'(len) + 32'd1) << size;
    for (int i = 0; i <= int'(len); i++) begin
      beat_t b;
      b.id       = id;
      b.resp     = err ? 2'b10 : 2'b00;
      b.last     = (i == int'(len));
      b.gap      = (i == 0 || !gap_en) ? 0 : (err ? 1 : 3);
      b.first_at = (i == 0) ? first_at : -1;
      if (err) b.data = 32'd0;
      else begin
        mem_q.push_back({a[31:2], 2'b00});
        b.data = mem_word({a[31:2], 2'b00});
      end
      exp_q.push_back(b);
      case (burst)
        2'd1:    a = a - (a % step) + step;
        2'd2:    a = (a - (a % l)) + (((a % l) + step) % l);
        default: a = a;
      endcase
    end
  endtask

  // Call just after a rising edge; returns just after the edge that completes the handshake
  task automatic send_ar(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit gap_en,
                         input bit lat_en, output int t_acc);
    bit ok;
    ok = 0;
    t_acc = -1;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (arready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    chk("ar_accept", 32'(ok), 32'd1);
    if (ok) begin
      t_acc = cyc;
      push_model(id, addr, len, size, burst, gap_en, lat_en ? cyc + 4 : -1);
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (exp_q.size() == 0 && mem_q.size() == 0) break;
      @(posedge clk);
    end
    chk("drain", 32'(exp_q.size() + mem_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_arready"},  32'(arready),  32'd0);
    chk({pfx, "_rvalid"},   32'(rvalid),   32'd0);
    chk({pfx, "_rlast"},    32'(rlast),    32'd0);
    chk({pfx, "_rresp"},    32'(rresp),    32'd0);
    chk({pfx, "_rid"},      32'(rid),      32'd0);
    chk({pfx, "_rdata"},    rdata,         32'd0);
    chk({pfx, "_mem_req"},  32'(mem_req),  32'd0);
    chk({pfx, "_mem_addr"}, mem_addr,      32'd0);
  endtask

  // Monitor: sampled on the falling edge, values reflect the upcoming rising edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req) begin
        if (mem_q.size() == 0) chk("mem_req_unexp", 32'(mem_req), 32'd0);
        else                   chk("mem_addr", mem_addr, mem_q.pop_front());
      end
      if (in_beat && !rvalid) begin
        chk("rvalid_drop", 32'(rvalid), 32'd1);
        in_beat = 0;
      end
      if (rvalid && !in_beat) begin
        in_beat   = 1;
        start_cyc = cyc;
      end
      if (rvalid) begin
        if (exp_q.size() == 0) begin
          if (rready) begin
            chk("beat_unexp", 32'(rvalid), 32'd0);
            in_beat = 0;
          end
        end else begin
          mon_e = exp_q[0];
          chk("rid",   32'(rid),   32'(mon_e.id));
          chk("rdata", rdata,      mon_e.data);
          chk("rresp", 32'(rresp), 32'(mon_e.resp));
          chk("rlast", 32'(rlast), 32'(mon_e.last));
          if (rready) begin
            if (mon_e.gap > 0)
              chk("beat_gap", 32'(start_cyc - last_hs_cyc), 32'(mon_e.gap));
            if (mon_e.first_at >= 0)
              chk("first_rvalid", 32'(start_cyc), 32'(mon_e.first_at));
            void'(exp_q.pop_front());
            last_hs_cyc = cyc;
            in_beat     = 0;
            n_hs++;
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1; rready = 1'b1; arvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("por");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arready_after_rst", 32'(arready), 32'd1);

    // INCR, WRAP, FIXED, narrow INCR
    send_ar(2'd2, 32'h100, 8'd3, 3'd2, 2'd1, 1, 1, t0);
    wait_done(100);
    send_ar(2'd1, 32'h108, 8'd3, 3'd2, 2'd2, 1, 0, t0);
    wait_done(100);
    send_ar(2'd3, 32'h40,  8'd2, 3'd2, 2'd0, 1, 0, t0);
    wait_done(100);
    send_ar(2'd0, 32'h3,   8'd2, 3'd0, 2'd1, 1, 0, t0);
    wait_done(100);

    // SLVERR bursts: oversize, reserved burst, WRAP with illegal length
    send_ar(2'd1, 32'h80, 8'd1, 3'd3, 2'd1, 1, 0, t0);
    wait_done(100);
    send_ar(2'd2, 32'h84, 8'd0, 3'd2, 2'd3, 1, 0, t0);
    wait_done(100);
    send_ar(2'd3, 32'h88, 8'd2, 3'd2, 2'd2, 1, 0, t0);
    wait_done(100);

    // Backpressure: queue fills while the first burst is stalled on rready
    rready = 1'b0;
    fork
      begin
        send_ar(2'd0, 32'h200, 8'd1, 3'd2, 2'd1, 0, 0, t0);
        send_ar(2'd1, 32'h210, 8'd1, 3'd2, 2'd1, 0, 0, t1);
        send_ar(2'd2, 32'h220, 8'd0, 3'd2, 2'd0, 0, 0, t2);
        send_ar(2'd3, 32'h230, 8'd1, 3'd2, 2'd2, 0, 0, t3);
      end
      begin
        repeat (14) @(negedge clk);
        chk("arready_full", 32'(arready), 32'd0);
        @(posedge clk); #1;
        rready = 1'b1;
      end
    join
    chk("ar2_cycle", 32'(t1 - t0), 32'd1);
    chk("ar3_cycle", 32'(t2 - t0), 32'd2);
    chk("ar4_held",  32'(t3 - t0 > 3), 32'd1);
    wait_done(200);

    // Reset during beat 2 of a long burst
    send_ar(2'd1, 32'h300, 8'd7, 3'd2, 2'd1, 1, 0, t0);
    n0 = n_hs;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (n_hs >= n0 + 1) break;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rvalid) break;
    end
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    exp_q.delete();
    mem_q.delete();
    in_beat = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send_ar(2'd3, 32'h500, 8'd1, 3'd2, 2'd1, 1, 1, t0);
    wait_done(100);
    repeat (10) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
